// File: rtl/siren_pkg.sv
// Shared types and the fixed pitch profiles for the siren sequencer.
package siren_pkg;

    typedef enum logic [1:0] {
        WAIL = 2'd0,
        YELP = 2'd1,
        HILO = 2'd2,
        AUTO = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        RUN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [13:0] lo;
        logic [13:0] hi;
        logic [7:0]  speed;
    } profile_t;

    // HILO steps by hi-lo (403); only its low byte fits the 8-bit wspeed output.
    localparam profile_t PROFILES [3] = '{
        '{lo: 14'd671, hi: 14'd2013, speed: 8'd8},
        '{lo: 14'd671, hi: 14'd2013, speed: 8'd64},
        '{lo: 14'd805, hi: 14'd1208, speed: 8'(1208 - 805)}
    };

    function automatic profile_t profile_of(input mode_e m);
        case (m)
            YELP:    return PROFILES[1];
            HILO:    return PROFILES[2];
            default: return PROFILES[0];
        endcase
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            WAIL:    return YELP;
            YELP:    return HILO;
            default: return WAIL;
        endcase
    endfunction

endpackage

// File: rtl/wclk_prescaler.sv
// Free-running divider producing the 50% wailing clock and a strobe on its rising toggle.
module wclk_prescaler #(
    parameter int unsigned DIV = 2_100_840
) (
    input  logic clk,
    input  logic reset,
    output logic wclk,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] HalfLast = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] Last     = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wclk_q, wclk_d;

    always_comb begin
        cnt_d  = (cnt_q == Last) ? '0 : cnt_q + CW'(1);
        wclk_d = wclk_q;
        if (cnt_q == HalfLast || cnt_q == Last) begin
            wclk_d = ~wclk_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            wclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wclk_q <= wclk_d;
        end
    end

    assign wclk = wclk_q;
    assign tick = (cnt_q == HalfLast);

endmodule

// File: rtl/siren_sequencer.sv
// Siren controller: sequences muted gaps and pitch profiles for the wail datapath.
module siren_sequencer
    import siren_pkg::*;
#(
    parameter int unsigned WCLK_DIV    = 2_100_840,
    parameter int unsigned GAP_TICKS   = 4,
    parameter int unsigned DWELL_TICKS = 143
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode_sel,
    input  logic        mode_load,
    output logic        wclk,
    output logic [13:0] lo_pitch,
    output logic [13:0] hi_pitch,
    output logic [7:0]  wspeed,
    output logic        mute,
    output logic        active,
    output logic [1:0]  cur_mode
);

    localparam int unsigned GW = $clog2(GAP_TICKS + 1);
    localparam int unsigned DW = $clog2(DWELL_TICKS + 1);
    localparam logic [GW-1:0] GapLast   = GW'(GAP_TICKS - 1);
    localparam logic [DW-1:0] DwellLast = DW'(DWELL_TICKS - 1);

    logic tick;

    wclk_prescaler #(
        .DIV (WCLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .wclk  (wclk),
        .tick  (tick)
    );

    state_e        state_q, state_d;
    mode_e         sel_q, sel_d;
    mode_e         target_q, target_d;
    logic          auto_q, auto_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] dwell_q, dwell_d;
    profile_t      prof_q, prof_d;
    mode_e         cur_q, cur_d;
    logic          mute_q, mute_d;
    logic          active_q, active_d;
    mode_e         sel_in;

    always_comb begin
        sel_in   = mode_e'(mode_sel);
        state_d  = state_q;
        sel_d    = sel_q;
        target_d = target_q;
        auto_d   = auto_q;
        gap_d    = gap_q;
        dwell_d  = dwell_q;
        prof_d   = prof_q;
        cur_d    = cur_q;

        if (stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = GAP;
                        sel_d    = sel_in;
                        target_d = (sel_in == AUTO) ? WAIL : sel_in;
                        auto_d   = (sel_in == AUTO);
                        gap_d    = '0;
                    end
                end
                GAP: begin
                    // A retarget during the gap keeps the gap count running.
                    if (mode_load) begin
                        sel_d    = sel_in;
                        target_d = (sel_in == AUTO) ? WAIL : sel_in;
                        auto_d   = (sel_in == AUTO);
                    end
                    if (tick) begin
                        if (gap_q == GapLast) begin
                            state_d = RUN;
                            prof_d  = profile_of(target_d);
                            cur_d   = target_d;
                            gap_d   = '0;
                            dwell_d = '0;
                        end else begin
                            gap_d = gap_q + GW'(1);
                        end
                    end
                end
                RUN: begin
                    if (mode_load && sel_in != sel_q) begin
                        state_d  = GAP;
                        sel_d    = sel_in;
                        target_d = (sel_in == AUTO) ? WAIL : sel_in;
                        auto_d   = (sel_in == AUTO);
                        gap_d    = '0;
                    end else if (auto_q && tick) begin
                        if (dwell_q == DwellLast) begin
                            state_d  = GAP;
                            target_d = next_mode(cur_q);
                            gap_d    = '0;
                        end else begin
                            dwell_d = dwell_q + DW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        mute_d   = (state_d != RUN);
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= WAIL;
            target_q <= WAIL;
            auto_q   <= 1'b0;
            gap_q    <= '0;
            dwell_q  <= '0;
            prof_q   <= '0;
            cur_q    <= WAIL;
            mute_q   <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            target_q <= target_d;
            auto_q   <= auto_d;
            gap_q    <= gap_d;
            dwell_q  <= dwell_d;
            prof_q   <= prof_d;
            cur_q    <= cur_d;
            mute_q   <= mute_d;
            active_q <= active_d;
        end
    end

    assign lo_pitch = prof_q.lo;
    assign hi_pitch = prof_q.hi;
    assign wspeed   = prof_q.speed;
    assign cur_mode = cur_q;
    assign mute     = mute_q;
    assign active   = active_q;

endmodule

// File: tb/tb_siren_sequencer.sv
// Self-checking bench for siren_sequencer with a short prescaler and tick counts.
module tb_siren_sequencer;

    localparam int unsigned DIV   = 8;
    localparam int unsigned GAP   = 2;
    localparam int unsigned DWELL = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode_sel = 2'd0;
    logic        mode_load = 1'b0;
    logic        wclk;
    logic [13:0] lo_pitch;
    logic [13:0] hi_pitch;
    logic [7:0]  wspeed;
    logic        mute;
    logic        active;
    logic [1:0]  cur_mode;

    siren_sequencer #(
        .WCLK_DIV    (DIV),
        .GAP_TICKS   (GAP),
        .DWELL_TICKS (DWELL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode_sel  (mode_sel),
        .mode_load (mode_load),
        .wclk      (wclk),
        .lo_pitch  (lo_pitch),
        .hi_pitch  (hi_pitch),
        .wspeed    (wspeed),
        .mute      (mute),
        .active    (active),
        .cur_mode  (cur_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] lo;
        logic [13:0] hi;
        logic [7:0]  ws;
        logic [1:0]  cur;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        exp_t       e;
    } vec_t;

    // HILO speed is 1208-805 = 403, which the 8-bit port carries as 403 mod 256 = 147.
    localparam exp_t WailE = '{lo: 14'd671, hi: 14'd2013, ws: 8'd8,   cur: 2'd0};
    localparam exp_t YelpE = '{lo: 14'd671, hi: 14'd2013, ws: 8'd64,  cur: 2'd1};
    localparam exp_t HiloE = '{lo: 14'd805, hi: 14'd1208, ws: 8'd147, cur: 2'd2};

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb: got empty queue want an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_lo"}, 32'(lo_pitch), 32'(e.lo));
            check({tag, "_hi"}, 32'(hi_pitch), 32'(e.hi));
            check({tag, "_ws"}, 32'(wspeed), 32'(e.ws));
            check({tag, "_cur"}, 32'(cur_mode), 32'(e.cur));
        end
    endtask

    // Step until mute equals val, counting wclk rising edges seen on the way.
    task automatic wait_mute(input logic val, output int unsigned nrise, output bit ok);
        logic prev;
        prev  = wclk;
        nrise = 0;
        ok    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (wclk && !prev) nrise++;
            prev = wclk;
            if (mute == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rise(input string tag);
        logic prev;
        bit   seen;
        prev = wclk;
        seen = 1'b0;
        for (int i = 0; i < 4 * DIV && !seen; i++) begin
            cyc();
            if (wclk && !prev) seen = 1'b1;
            prev = wclk;
        end
        check({tag, "_rise"}, 32'(seen), 32'd1);
    endtask

    // Park one cycle after a tick so the next pulse never lands on a tick edge.
    task automatic sync(input string tag);
        wait_rise(tag);
        cyc();
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        mode_sel = sel;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic pulse_load(input logic [1:0] sel);
        mode_sel  = sel;
        mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        vec_t        vecs[4];
        int unsigned n;
        int unsigned hi_cnt;
        int unsigned per;
        bit          ok;

        vecs[0] = '{sel: 2'd0, e: WailE};
        vecs[1] = '{sel: 2'd1, e: YelpE};
        vecs[2] = '{sel: 2'd2, e: HiloE};
        vecs[3] = '{sel: 2'd3, e: WailE};

        // Reset held
        reset = 1'b1;
        cyc();
        cyc();
        check("rst_mute", 32'(mute), 32'd1);
        check("rst_active", 32'(active), 32'd0);
        check("rst_wclk", 32'(wclk), 32'd0);
        check("rst_lo", 32'(lo_pitch), 32'd0);
        check("rst_hi", 32'(hi_pitch), 32'd0);
        check("rst_ws", 32'(wspeed), 32'd0);
        check("rst_cur", 32'(cur_mode), 32'd0);
        reset = 1'b0;

        // wclk shape
        wait_rise("period");
        hi_cnt = 0;
        for (int i = 0; i < 20 && wclk; i++) begin
            hi_cnt++;
            cyc();
        end
        per = hi_cnt;
        for (int i = 0; i < 20 && !wclk; i++) begin
            per++;
            cyc();
        end
        check("wclk_high", hi_cnt, 32'd4);
        check("wclk_period", per, 32'd8);

        // Table: start each mode from IDLE
        for (int v = 0; v < 4; v++) begin
            sync("tbl");
            sb.push_back(vecs[v].e);
            pulse_start(vecs[v].sel);
            check("tbl_active", 32'(active), 32'd1);
            check("tbl_gap_mute", 32'(mute), 32'd1);
            wait_mute(1'b0, n, ok);
            check("tbl_run", 32'(ok), 32'd1);
            check("tbl_gap_ticks", n, GAP);
            sb_check("tbl");
            pulse_stop();
            check("tbl_stop_mute", 32'(mute), 32'd1);
            check("tbl_stop_active", 32'(active), 32'd0);
            check("tbl_hold_lo", 32'(lo_pitch), 32'(vecs[v].e.lo));
        end

        // RUN WAIL then mode_load HILO
        sync("ld");
        sb.push_back(WailE);
        pulse_start(2'd0);
        wait_mute(1'b0, n, ok);
        sb_check("ld_wail");
        sync("ld2");
        sb.push_back(HiloE);
        pulse_load(2'd2);
        check("ld_mute", 32'(mute), 32'd1);
        check("ld_hold_ws", 32'(wspeed), 32'd8);
        wait_mute(1'b0, n, ok);
        check("ld_run", 32'(ok), 32'd1);
        check("ld_gap_ticks", n, GAP);
        sb_check("ld_hilo");

        // Reloading the current selection is a no-op
        pulse_load(2'd2);
        cyc();
        check("same_ld_mute", 32'(mute), 32'd0);
        check("same_ld_cur", 32'(cur_mode), 32'd2);

        // stop beats mode_load
        mode_sel  = 2'd1;
        mode_load = 1'b1;
        stop      = 1'b1;
        cyc();
        mode_load = 1'b0;
        stop      = 1'b0;
        check("stopld_mute", 32'(mute), 32'd1);
        check("stopld_active", 32'(active), 32'd0);
        check("stopld_hold_hi", 32'(hi_pitch), 32'd1208);

        // mode_load in IDLE is ignored
        pulse_load(2'd0);
        cyc();
        check("idle_ld_active", 32'(active), 32'd0);

        // mode_load inside GAP retargets without restarting the gap
        sync("gld");
        sb.push_back(YelpE);
        pulse_start(2'd0);
        wait_rise("gld_first");
        pulse_load(2'd1);
        wait_mute(1'b0, n, ok);
        check("gld_run", 32'(ok), 32'd1);
        check("gld_remaining", n, GAP - 1);
        sb_check("gld");
        pulse_stop();

        // AUTO rotation
        sync("auto");
        sb.push_back(WailE);
        sb.push_back(YelpE);
        sb.push_back(HiloE);
        sb.push_back(WailE);
        pulse_start(2'd3);
        for (int k = 0; k < 4; k++) begin
            wait_mute(1'b0, n, ok);
            check("auto_run", 32'(ok), 32'd1);
            check("auto_gap_ticks", n, GAP);
            sb_check("auto");
            if (k < 3) begin
                wait_mute(1'b1, n, ok);
                check("auto_gap", 32'(ok), 32'd1);
                check("auto_dwell", n, DWELL);
            end
        end
        pulse_stop();

        // Async reset mid-GAP
        sync("mrst");
        pulse_start(2'd1);
        cyc();
        reset = 1'b1;
        #1;
        check("mrst_mute", 32'(mute), 32'd1);
        check("mrst_active", 32'(active), 32'd0);
        check("mrst_wclk", 32'(wclk), 32'd0);
        check("mrst_lo", 32'(lo_pitch), 32'd0);
        check("mrst_ws", 32'(wspeed), 32'd0);
        check("mrst_cur", 32'(cur_mode), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        sync("mrst2");
        sb.push_back(YelpE);
        pulse_start(2'd1);
        wait_mute(1'b0, n, ok);
        check("mrst_run", 32'(ok), 32'd1);
        check("mrst_gap_ticks", n, GAP);
        sb_check("mrst");

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
